shr_out_stage: RTL
==================

# shr_out_stage

Registered output stage placed directly downstream of the logical right shifter in the datapath. It captures the shifter result `d` under a valid/ready handshake, holds it stable for the consumer, and absorbs one cycle of consumer back-pressure through a two-entry skid buffer. It also flags zero results and counts delivered results, so no data is lost or duplicated when the consumer stalls.

## Interface
Parameters:
- `DATAWIDTH`, default 2: width of the shifter result and of `q`.
- `CNTWIDTH`, default 8: width of the delivered-result counter.

Ports:
- `Clk`  in  1  system clock; all state changes on the rising edge.
- `Rst`  in  1  reset, synchronous and active-high.
- `in_valid`  in  1  upstream (shifter side) presents a valid `d`.
- `in_ready`  out  1  stage can accept `d` this cycle.
- `d`  in  DATAWIDTH  shifter result.
- `out_valid`  out  1  `q` holds an undelivered result.
- `out_ready`  in  1  consumer accepts `q` this cycle.
- `q`  out  DATAWIDTH  oldest undelivered result.
- `q_zero`  out  1  `q` equals zero; meaningful only when `out_valid`=1.
- `xfer_cnt`  out  CNTWIDTH  number of results delivered since reset, modulo 2^CNTWIDTH.

## Operation
- Input transfer occurs when `in_valid` & `in_ready`. Output transfer occurs when `out_valid` & `out_ready`.
- Storage consists of a main register, which drives `q`, and a skid register. A 2-bit state register holds one of three values:
  - EMPTY: no data held.
  - ONE: main register holds data.
  - FULL: main and skid registers both hold data.
- All outputs are decoded from registers, with no combinational path from an input to an output:
  - `in_ready` = (state != FULL).
  - `out_valid` = (state != EMPTY).
- Transitions:
  - EMPTY, input transfer: main <= `d`; go to ONE.
  - ONE, input and output transfer together: main <= `d`; stay in ONE.
  - ONE, input transfer only: skid <= `d`; go to FULL.
  - ONE, output transfer only: go to EMPTY.
  - FULL, output transfer: main <= skid; go to ONE. `in_valid` is ignored because `in_ready`=0.
  - Any other combination: hold all state.
- `q_zero` is a register, loaded with (loaded value == 0) whenever main is loaded.
- `xfer_cnt` increments by 1 on each output transfer. It wraps from 2^CNTWIDTH−1 to 0 and has no saturation.
- Ordering is strict FIFO. A result is never dropped, duplicated, or reordered.
- The skid register contents are don't-care outside FULL.

## Timing
- Reset values, taking effect on the first rising edge with `Rst`=1: state = EMPTY, `out_valid`=0, `in_ready`=1, `q`=0, `q_zero`=1, `xfer_cnt`=0, skid = 0.
- While `Rst`=1, handshakes are ignored. Reset asserted mid-operation discards any held data at that edge.
- Latency: `d` accepted at edge N appears on `q` with `out_valid`=1 after edge N if the stage was EMPTY. It appears one edge after the preceding result leaves if the stage was not EMPTY.
- Throughput: one result per cycle when `out_ready` is held at 1.
- `in_ready` falls in the cycle after the skid register fills. It rises again in the cycle after the first output transfer from FULL.
- While `out_valid`=1 and `out_ready`=0, `q` and `q_zero` are stable.

## Structure
- Shared package `shr_pkg` holds:
  - state encodings as localparams: EMPTY=2'd0, ONE=2'd1, FULL=2'd2;
  - the default `DATAWIDTH` and `CNTWIDTH` constants.
- A single flat module is sufficient. No sub-module is required.
- The shifter is instantiated by the enclosing datapath, not inside this block.

## Test plan
All scenarios use `DATAWIDTH`=8.
1. Reset, then `in_valid`=1, `d`=8'h5A, `out_ready`=1 -> `out_valid`=1 and `q`=8'h5A one cycle later; `q_zero`=0; `xfer_cnt`=1 after the next edge.
2. Stream 8'h01, 8'h02, 8'h03 on consecutive cycles with `out_ready`=1 -> `q` shows 01, 02, 03 on consecutive cycles; `in_ready` stays 1.
3. Hold `out_ready`=0 and send 8'h10 then 8'h20 -> `in_ready`=0 after the second accept; `q`=8'h10 stable. Then raise `out_ready` -> `q` shows 10 then 20; `in_ready` returns to 1.
4. `d`=8'h00 accepted -> `q_zero`=1. Then `d`=8'h80 -> `q_zero`=0.
5. With `CNTWIDTH`=2, complete 5 output transfers -> `xfer_cnt` sequence 1, 2, 3, 0, 1.
6. Assert `Rst` while in FULL with 8'hAA and 8'hBB held -> next cycle `out_valid`=0, `q`=0, `in_ready`=1, `xfer_cnt`=0; neither value is ever delivered.

Source files
------------

// File: rtl/shr_pkg.sv
// Shared constants for the shifter output stage: state encodings and default widths.
package shr_pkg;

    localparam logic [1:0] EMPTY = 2'd0;
    localparam logic [1:0] ONE   = 2'd1;
    localparam logic [1:0] FULL  = 2'd2;

    localparam int DEFAULT_DATAWIDTH = 2;
    localparam int DEFAULT_CNTWIDTH  = 8;

endpackage

// File: rtl/shr_out_stage.sv
// Registered output stage behind the logical right shifter: two-entry skid buffer
// with a registered zero flag and a delivered-result counter.
module shr_out_stage
    import shr_pkg::*;
#(
    parameter int DATAWIDTH = DEFAULT_DATAWIDTH,
    parameter int CNTWIDTH  = DEFAULT_CNTWIDTH
) (
    input  logic                 Clk,
    input  logic                 Rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [DATAWIDTH-1:0] d,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [DATAWIDTH-1:0] q,
    output logic                 q_zero,
    output logic [CNTWIDTH-1:0]  xfer_cnt
);

    logic [1:0]           state_r;
    logic [DATAWIDTH-1:0] main_r;
    logic [DATAWIDTH-1:0] skid_r;
    logic                 zero_r;
    logic [CNTWIDTH-1:0]  cnt_r;
    logic                 in_xfer_s;
    logic                 out_xfer_s;

    // Handshake flags are decoded from the state register only, so no input reaches an output.
    assign in_ready   = (state_r != FULL);
    assign out_valid  = (state_r != EMPTY);
    assign in_xfer_s  = in_valid & in_ready;
    assign out_xfer_s = out_valid & out_ready;

    assign q        = main_r;
    assign q_zero   = zero_r;
    assign xfer_cnt = cnt_r;

    // Skid-buffer state machine, storage registers and delivery counter.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_r <= EMPTY;
            main_r  <= '0;
            skid_r  <= '0;
            zero_r  <= 1'b1;
            cnt_r   <= '0;
        end else begin
            case (state_r)
                EMPTY: begin
                    if (in_xfer_s) begin
                        main_r  <= d;
                        zero_r  <= (d == '0);
                        state_r <= ONE;
                    end
                end
                ONE: begin
                    if (in_xfer_s && out_xfer_s) begin
                        main_r <= d;
                        zero_r <= (d == '0);
                    end else if (in_xfer_s) begin
                        skid_r  <= d;
                        state_r <= FULL;
                    end else if (out_xfer_s) begin
                        state_r <= EMPTY;
                    end
                end
                FULL: begin
                    // in_ready is low here, so the upstream side cannot transfer.
                    if (out_xfer_s) begin
                        main_r  <= skid_r;
                        zero_r  <= (skid_r == '0);
                        state_r <= ONE;
                    end
                end
                default: begin
                    state_r <= EMPTY;
                end
            endcase

            if (out_xfer_s) begin
                cnt_r <= cnt_r + {{(CNTWIDTH-1){1'b0}}, 1'b1};
            end
        end
    end

endmodule
